// File: rtl/bsg_wormhole_link_arbiter.sv
// bsg_wormhole_link_arbiter
// Shares one wormhole ready-and output link among num_in_p input links.
// Arbitration happens only on header flits. The grant is then locked for
// the header plus len body flits, so packets never interleave. The datapath
// is a 0-cycle combinational pass-through. Only the grant, state, remaining
// flit count and round-robin pointer are registered.
//
// Build option:
//   BSG_WORMHOLE_LINK_ARBITER_FIXED_PRIORITY_EN
//     - Defined: IDLE arbitration uses fixed priority (lowest index wins),
//       and no round-robin pointer register is built.
//     - Undefined (default): round-robin arbitration.

module bsg_wormhole_link_arbiter #(
    parameter int num_in_p     = 4,
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p-1:0]              v_i,
    input  logic [num_in_p*flit_width_p-1:0] data_i,
    output logic [num_in_p-1:0]              ready_and_o,
    output logic                             v_o,
    output logic [flit_width_p-1:0]          data_o,
    input  logic                             ready_and_i,
    output logic [num_in_p-1:0]              grant_o,
    output logic                             busy_o
);

    localparam int ptr_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HDR_STALL = 2'd1,
        ST_BODY      = 2'd2
    } state_e;

    // Registered state
    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [num_in_p-1:0]     gnt_r;
    logic [num_in_p-1:0]     gnt_nxt_s;
    logic [len_width_p-1:0]  rem_r;
    logic [len_width_p-1:0]  rem_nxt_s;
    logic                    busy_r;

    // Arbitration and datapath
    logic [ptr_width_lp-1:0] ptr_s;
    int                      cand_sum_s;
    logic [ptr_width_lp-1:0] cand_idx_s;
    logic                    arb_found_s;
    logic [num_in_p-1:0]     arb_gnt_s;
    logic [num_in_p-1:0]     grant_s;
    logic [flit_width_p-1:0] data_s;
    logic                    v_s;
    logic                    xfer_s;
    logic [len_width_p-1:0]  hdr_len_s;

`ifndef BSG_WORMHOLE_LINK_ARBITER_FIXED_PRIORITY_EN
    logic [ptr_width_lp-1:0] ptr_r;
    logic [ptr_width_lp-1:0] ptr_nxt_s;
    logic [ptr_width_lp-1:0] win_idx_s;
    logic                    hdr_xfer_s;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic logic [ptr_width_lp-1:0] onehot_to_idx(input logic [num_in_p-1:0] oh);
        logic [ptr_width_lp-1:0] idx;
        idx = '0;
        for (int i = 0; i < num_in_p; i++) begin
            if (oh[i]) begin
                idx = idx | ptr_width_lp'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Round-robin successor of an input index, wrapping at num_in_p.
    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] idx);
        logic [ptr_width_lp-1:0] nxt;
        if (idx == ptr_width_lp'(num_in_p - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + ptr_width_lp'(1);
        end
        return nxt;
    endfunction

    assign ptr_s      = ptr_r;
    assign win_idx_s  = onehot_to_idx(grant_s);
    assign hdr_xfer_s = xfer_s & (state_r != ST_BODY);

    // Advance the search pointer just past the winner once its header is accepted.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (hdr_xfer_s) begin
            ptr_nxt_s = next_ptr(win_idx_s);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end
`else
    // Fixed priority: the search always starts at input 0.
    assign ptr_s = '0;
`endif

    // Find the first valid input at or above ptr_s, wrapping around.
    always_comb begin
        arb_gnt_s   = '0;
        arb_found_s = 1'b0;
        cand_sum_s  = 0;
        cand_idx_s  = '0;
        for (int i = 0; i < num_in_p; i++) begin
            cand_sum_s = int'(ptr_s) + i;
            if (cand_sum_s >= num_in_p) begin
                cand_idx_s = ptr_width_lp'(cand_sum_s - num_in_p);
            end else begin
                cand_idx_s = ptr_width_lp'(cand_sum_s);
            end
            if (!arb_found_s && v_i[cand_idx_s]) begin
                arb_gnt_s[cand_idx_s] = 1'b1;
                arb_found_s           = 1'b1;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Live arbitration in IDLE. Once a header has stalled or a packet is in
    // flight, the grant is frozen.
    always_comb begin
        grant_s = '0;
        case (state_r)
            ST_IDLE:      grant_s = arb_gnt_s;
            ST_HDR_STALL: grant_s = gnt_r;
            ST_BODY:      grant_s = gnt_r;
            default:      grant_s = '0;
        endcase
    end

    // One-hot AND-OR mux of the granted input's flit. Zero when nothing is granted.
    always_comb begin
        data_s = '0;
        for (int i = 0; i < num_in_p; i++) begin
            if (grant_s[i]) begin
                data_s = data_s | data_i[i*flit_width_p +: flit_width_p];
            end else begin
                data_s = data_s;
            end
        end
    end

    assign v_s       = |(v_i & grant_s);
    assign xfer_s    = v_s & ready_and_i;
    assign hdr_len_s = data_s[cord_width_p +: len_width_p];

    // Packet-level FSM: header acceptance, header stall and body counting.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        rem_nxt_s   = rem_r;
        case (state_r)
            ST_IDLE, ST_HDR_STALL: begin
                if (xfer_s) begin
                    if (hdr_len_s == '0) begin
                        state_nxt_s = ST_IDLE;
                        gnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_BODY;
                        gnt_nxt_s   = grant_s;
                        rem_nxt_s   = hdr_len_s;
                    end
                end else if (v_s) begin
                    // Freeze the winner so data_o cannot switch mid-stall.
                    state_nxt_s = ST_HDR_STALL;
                    gnt_nxt_s   = grant_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_BODY: begin
                if (xfer_s) begin
                    rem_nxt_s = rem_r - len_width_p'(1);
                    if (rem_r == len_width_p'(1)) begin
                        state_nxt_s = ST_IDLE;
                        gnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_BODY;
                    end
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = '0;
                rem_nxt_s   = '0;
            end
        endcase
    end

    // State, locked grant, remaining body count and registered busy flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            rem_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            rem_r   <= rem_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign ready_and_o = grant_s & {num_in_p{ready_and_i}};
    assign v_o         = v_s;
    assign data_o      = data_s;
    assign grant_o     = grant_s;
    assign busy_o      = busy_r;

endmodule

// File: doc/bsg_wormhole_link_arbiter.md
Name: bsg_wormhole_link_arbiter

Overview:
- Shares one wormhole ready-and output link among num_in_p wormhole input links, e.g. several ruche/vertical links feeding a single nonsynth wormhole test memory or memory channel.
- Arbitrates only on header flits, then locks the grant for the whole packet (header plus len body flits), so packets are never interleaved.
- Datapath is combinational pass-through with 0-cycle latency; only grant, state and flit-count state are registered.

Parameters:
- num_in_p, 4: number of input wormhole links, >=2.
- flit_width_p, 32: wormhole flit width in bits.
- cord_width_p, 7: destination cord field width; header bits [cord_width_p-1:0].
- len_width_p, 4: body-flit count field width; header bits [cord_width_p +: len_width_p].

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous reset, active-high.
- v_i  in  num_in_p  per-input flit valid.
- data_i  in  num_in_p*flit_width_p  per-input flit data; slot i is at [i*flit_width_p +: flit_width_p].
- ready_and_o  out  num_in_p  per-input ready.
- v_o  out  1  output flit valid.
- data_o  out  flit_width_p  output flit data.
- ready_and_i  in  1  downstream ready.
- grant_o  out  num_in_p  one-hot current owner; 0 when no input is selected.
- busy_o  out  1  high in HDR_STALL or BODY.

Behaviour:
- Transfers:
  - An input transfer occurs when v_i[k] & ready_and_o[k].
  - An output transfer occurs when v_o & ready_and_i.
  - ready_and_o[k] = ready_and_i & grant_o[k]. Other inputs see 0.
  - v_o = |(v_i & grant_o). data_o = data_i slot of the granted input, or 0 if there is no grant.
  - Inputs follow ready-and: valid and data are held until the transfer.
- States: IDLE, HDR_STALL, BODY. A 2-bit state register, a num_in_p-bit grant register gnt_r, a len_width_p-bit remaining counter rem_r, and a round-robin pointer ptr_r.
- IDLE:
  - Combinational grant = first set bit of v_i, searching from ptr_r upward and wrapping. grant_o = that one-hot value, 0 if v_i==0.
  - Header transfer with len==0: stay IDLE, ptr_r <= winner+1 mod num_in_p.
  - Header transfer with len>0: go to BODY, rem_r <= len, gnt_r <= winner, ptr_r <= winner+1 mod num_in_p.
  - Winner valid but ready_and_i=0: go to HDR_STALL, gnt_r <= winner. The grant is frozen, so data_o cannot switch to another input mid-stall.
- HDR_STALL:
  - grant_o = gnt_r.
  - On header transfer, the len==0 and len>0 transitions are the same as in IDLE.
  - ptr_r is unchanged until the transfer.
- BODY:
  - grant_o = gnt_r.
  - Each output transfer decrements rem_r.
  - A transfer with rem_r==1 returns to IDLE; rem_r reaches 0.
  - Bubbles (v_i low or ready_and_i low) hold all state.
- len arithmetic: the len field is unsigned. The maximum 2^len_width_p-1 body flits must work, with no overflow in rem_r.
- Simultaneous requests: exactly one grant per header. Non-granted inputs are stalled and are never dropped.
- Reset (asynchronous, any time including mid-packet):
  - state=IDLE, gnt_r=0, rem_r=0, ptr_r=0.
  - Outputs settle to busy_o=0. ready_and_o, v_o, data_o and grant_o then reflect a fresh IDLE arbitration.
  - A partial packet is abandoned; resynchronizing it is the system's responsibility.
- Fairness: with all inputs continuously valid, each input wins once every num_in_p packets.

Optional Feature:
- Macro: BSG_WORMHOLE_LINK_ARBITER_FIXED_PRIORITY_EN.
- Defined: IDLE arbitration is fixed priority, lowest index wins. ptr_r is not implemented and is treated as 0.
- Undefined (default): round-robin as specified above.
- Packet locking, HDR_STALL and the reset behaviour are identical in both modes.

Test Plan:
- Single-flit packets: in0 presents header len=0 with ready_and_i=1 -> v_o=1 and data_o=in0 header in the same cycle. State stays IDLE and ptr_r becomes 1.
- Packet lock: in0 sends len=3 while in1 is continuously valid -> exactly 4 flits out from in0, ready_and_o[1]=0 throughout, then the in1 header wins.
- Fairness: all 4 inputs valid with len=0 packets -> output order 0,1,2,3,0,... With the FIXED_PRIORITY macro defined -> always 0.
- Header stall: in2 header with ready_and_i=0 for 5 cycles while in0 asserts valid at cycle 2 -> grant_o stays 0100 and data_o stays unchanged. The in2 header transfers when ready_and_i=1.
- Bubbles: len=15 packet with random v_i/ready_and_i gaps -> 16 flits transferred in order, busy_o drops after the 16th.
- Reset mid-packet: assert reset_i after 2 of 6 flits -> busy_o=0 and grant_o=0 (with v_i=0) asynchronously. A new header from in3 after reset is arbitrated normally.
